// File: rtl/silife_ctrl.sv
// silife_ctrl: control/timing block for the SiLife cellular-automaton core.
// Generation timer, burst stepping, generation counter, wrap select, irq.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   i_wb_cyc/stb/we/addr/data, o_wb_ack/data   Wishbone slave, window 0x000000-0x000FFF
//   o_step                  one-cycle pulse, matrix computes one generation
//   o_wrap                  torus edge mode
//   o_max7219_enable/reverse/brightness   display configuration
//   o_irq                   level interrupt, done & irq_en
//   i_step_gate             only with SILIFE_CTRL_STEP_GATE_EN: steps wait for this
//
// Optional feature macro: SILIFE_CTRL_STEP_GATE_EN
module silife_ctrl #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int TIMER_BITS = 24,
  parameter int GEN_BITS   = 32,
  parameter int BURST_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
`ifdef SILIFE_CTRL_STEP_GATE_EN
  input  logic        i_step_gate,
`endif
  output logic        o_step,
  output logic        o_wrap,
  output logic        o_max7219_enable,
  output logic        o_max7219_reverse,
  output logic [3:0]  o_max7219_brightness,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                 state;
  logic                   run_q;
  logic                   irq_en_q;
  logic                   done_q;
  logic                   manual_q;
  logic [TIMER_BITS-1:0]  tick_div_q;
  logic [TIMER_BITS-1:0]  timer_q;
  logic [GEN_BITS-1:0]    gen_q;
  logic [BURST_BITS-1:0]  remain_q;

  logic        unused_bits;
  assign unused_bits = ^{i_wb_addr[31:24], i_wb_data};

  logic        sel;
  logic        req;
  logic        wr;
  logic        rd;
  logic [11:0] off;

  assign sel = (i_wb_addr[23:12] == 12'h000);
  assign req = i_wb_cyc & i_wb_stb & sel & ~o_wb_ack;
  assign wr  = req & i_wb_we;
  assign rd  = req & ~i_wb_we;
  assign off = i_wb_addr[11:0];

  logic a_ctrl, a_max, a_bright, a_tick;
  logic a_burst, a_gen, a_status, a_info;

  assign a_ctrl   = (off == 12'h000);
  assign a_max    = (off == 12'h004);
  assign a_bright = (off == 12'h008);
  assign a_tick   = (off == 12'h00C);
  assign a_burst  = (off == 12'h010);
  assign a_gen    = (off == 12'h014);
  assign a_status = (off == 12'h018);
  assign a_info   = (off == 12'h01C);

  logic wr_ctrl, wr_max, wr_bright, wr_tick, wr_burst, wr_status;

  assign wr_ctrl   = wr & a_ctrl;
  assign wr_max    = wr & a_max;
  assign wr_bright = wr & a_bright;
  assign wr_tick   = wr & a_tick;
  assign wr_burst  = wr & a_burst;
  assign wr_status = wr & a_status;

  logic busy;
  logic expiry;
  logic burst_go;
  logic run_go;
  logic stop;
  logic last;
  logic leave;
  logic trig;
  logic fire;
  logic pend_bit;

  assign busy     = (state != IDLE);
  assign expiry   = busy && (timer_q == tick_div_q);
  assign burst_go = wr_burst && (i_wb_data[BURST_BITS-1:0] != '0);
  assign run_go   = wr_ctrl && i_wb_data[0] && (state == IDLE);
  assign stop     = wr_ctrl && !i_wb_data[0] && busy;
  // The pulse now on o_step finishes the burst: nothing may follow it.
  assign last     = (state == BURST) && o_step
                    && (remain_q == BURST_BITS'(1));
  assign leave    = stop || last;
  assign trig     = (expiry && !leave && !burst_go) || manual_q;

`ifdef SILIFE_CTRL_STEP_GATE_EN
  logic pend_q;
  assign fire     = pend_q && i_step_gate && !last;
  assign pend_bit = pend_q;
`else
  assign fire     = trig;
  assign pend_bit = 1'b0;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a_ctrl:   rdata = {28'h0, irq_en_q, o_wrap, 1'b0, run_q};
      a_max:    rdata = {30'h0, o_max7219_reverse,
                         o_max7219_enable};
      a_bright: rdata = {28'h0, o_max7219_brightness};
      a_tick:   rdata = 32'(tick_div_q);
      a_burst:  rdata = 32'(remain_q);
      a_gen:    rdata = 32'(gen_q);
      a_status: rdata = {29'h0, pend_bit, done_q, busy};
      a_info:   rdata = {16'(HEIGHT), 16'(WIDTH)};
      default:  rdata = '0;
    endcase
  end

  assign o_irq = done_q & irq_en_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      run_q                <= 1'b0;
      o_wrap               <= 1'b0;
      irq_en_q             <= 1'b0;
      done_q               <= 1'b0;
      manual_q             <= 1'b0;
      tick_div_q           <= '1;
      timer_q              <= '0;
      gen_q                <= '0;
      remain_q             <= '0;
      o_step               <= 1'b0;
      o_wb_ack             <= 1'b0;
      o_wb_data            <= '0;
      o_max7219_enable     <= 1'b0;
      o_max7219_reverse    <= 1'b1;
      o_max7219_brightness <= 4'hF;
`ifdef SILIFE_CTRL_STEP_GATE_EN
      pend_q               <= 1'b0;
`endif
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= rd ? rdata : '0;

      // Manual step lands one cycle after the ack cycle.
      manual_q <= wr_ctrl && i_wb_data[1] && (state == IDLE);
      o_step   <= fire;

      if (wr_ctrl) begin
        run_q    <= i_wb_data[0];
        o_wrap   <= i_wb_data[2];
        irq_en_q <= i_wb_data[3];
      end
      if (wr_max) begin
        o_max7219_enable  <= i_wb_data[0];
        o_max7219_reverse <= i_wb_data[1];
      end
      if (wr_bright)
        o_max7219_brightness <= i_wb_data[3:0];
      if (wr_tick)
        tick_div_q <= i_wb_data[TIMER_BITS-1:0];

      if (wr_ctrl && i_wb_data[4])
        gen_q <= '0;
      else if (o_step)
        gen_q <= gen_q + 1'b1;

      done_q <= (done_q & ~(wr_status & i_wb_data[1])) | last;

      if (run_go || burst_go)
        timer_q <= '0;
      else if (busy)
        timer_q <= expiry ? '0 : timer_q + 1'b1;
      else
        timer_q <= '0;

      if (burst_go) begin
        state    <= BURST;
        remain_q <= i_wb_data[BURST_BITS-1:0];
      end else begin
        unique case (state)
          IDLE:
            if (run_go)
              state <= RUN;
          RUN:
            if (stop)
              state <= IDLE;
          BURST:
            if (stop) begin
              state    <= IDLE;
              remain_q <= '0;
            end else if (o_step) begin
              remain_q <= remain_q - 1'b1;
              if (last)
                state <= IDLE;
            end
          default:
            state <= IDLE;
        endcase
      end

`ifdef SILIFE_CTRL_STEP_GATE_EN
      if (leave)
        pend_q <= 1'b0;
      else
        pend_q <= (pend_q & ~fire) | trig;
`endif
    end
  end

endmodule

// File: tb/tb_silife_ctrl.sv
// tb_silife_ctrl: directed bench for silife_ctrl.
// Built with GEN_BITS=4 so generation wrap is reachable.
module tb_silife_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [31:0] i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
`ifdef SILIFE_CTRL_STEP_GATE_EN
  logic        i_step_gate = 1'b1;
`endif
  logic        o_step;
  logic        o_wrap;
  logic        o_max7219_enable;
  logic        o_max7219_reverse;
  logic [3:0]  o_max7219_brightness;
  logic        o_irq;

  silife_ctrl #(
    .WIDTH(8), .HEIGHT(8), .TIMER_BITS(24),
    .GEN_BITS(4), .BURST_BITS(16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .i_wb_cyc             (i_wb_cyc),
    .i_wb_stb             (i_wb_stb),
    .i_wb_we              (i_wb_we),
    .i_wb_addr            (i_wb_addr),
    .i_wb_data            (i_wb_data),
    .o_wb_ack             (o_wb_ack),
    .o_wb_data            (o_wb_data),
`ifdef SILIFE_CTRL_STEP_GATE_EN
    .i_step_gate          (i_step_gate),
`endif
    .o_step               (o_step),
    .o_wrap               (o_wrap),
    .o_max7219_enable     (o_max7219_enable),
    .o_max7219_reverse    (o_max7219_reverse),
    .o_max7219_brightness (o_max7219_brightness),
    .o_irq                (o_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int pulse_cyc[$];
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset_n && o_step) pulse_cyc.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr,
                      input logic [31:0] data,
                      output logic [31:0] rdat, output logic got);
    int k;
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = data;
    got  = 1'b0;
    rdat = '0;
    k = 0;
    while (!got && k < 6) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) begin
        got  = 1'b1;
        rdat = o_wb_data;
      end
      k++;
    end
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wb_wr(input string tag, input logic [31:0] addr,
                       input logic [31:0] data);
    logic [31:0] r;
    logic g;
    xfer(1'b1, addr, data, r, g);
    chk({tag, "_ack"}, {31'h0, g}, 32'h1);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp);
    logic [31:0] r;
    logic g;
    xfer(1'b0, addr, 32'h0, r, g);
    chk({tag, "_ack"}, {31'h0, g}, 32'h1);
    chk(tag, r, exp);
  endtask

  task automatic chk_period(input string tag, input int base,
                            input int per);
    int bad;
    bad = 0;
    for (int i = base + 1; i < pulse_cyc.size(); i++)
      if (pulse_cyc[i] - pulse_cyc[i-1] != per) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] r;
    logic g;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", {31'h0, o_step}, 32'h0);
    chk("rst_ack", {31'h0, o_wb_ack}, 32'h0);
    chk("rst_data", o_wb_data, 32'h0);
    chk("rst_irq", {31'h0, o_irq}, 32'h0);
    chk("rst_wrap", {31'h0, o_wrap}, 32'h0);
    chk("rst_en", {31'h0, o_max7219_enable}, 32'h0);
    chk("rst_rev", {31'h0, o_max7219_reverse}, 32'h1);
    chk("rst_bright", {28'h0, o_max7219_brightness}, 32'hF);
    reset_n = 1'b1;

    wb_rd("rd_bright", 32'h008, 32'h0000000F);
    wb_rd("rd_tick", 32'h00C, 32'h00FFFFFF);
    wb_rd("rd_info", 32'h01C, 32'h00080008);
    wb_rd("rd_max", 32'h004, 32'h00000002);
    wb_rd("rd_gen0", 32'h014, 32'h0);
    wb_rd("rd_stat0", 32'h018, 32'h0);
    wb_rd("rd_burst0", 32'h010, 32'h0);
    chk("rst_nostep", pulse_cyc.size(), 0);

    // Manual steps: pulse exactly one cycle after each ack
    base = pulse_cyc.size();
    for (int i = 0; i < 3; i++) begin
      wb_wr("man_wr", 32'h000, 32'h2);
      chk("man_ackcyc", {31'h0, o_step}, 32'h0);
      @(posedge clk); #1;
      chk("man_pulse", {31'h0, o_step}, 32'h1);
      @(posedge clk); #1;
      chk("man_after", {31'h0, o_step}, 32'h0);
    end
    chk("man_count", pulse_cyc.size() - base, 3);
    wb_rd("man_gen", 32'h014, 32'h3);
    wb_rd("man_ctrl", 32'h000, 32'h0);

    // Free run, TICK_DIV=4 -> period 5, pulses at +5..+50
    wb_wr("gclr", 32'h000, 32'h10);
    wb_rd("gclr_gen", 32'h014, 32'h0);
    wb_wr("fr_div", 32'h00C, 32'h4);
    base = pulse_cyc.size();
    wb_wr("fr_run", 32'h000, 32'h1);
    wb_rd("fr_busy", 32'h018, 32'h1);
    repeat (48) @(posedge clk);
    #1;
    wb_wr("fr_stop", 32'h000, 32'h0);
    n = pulse_cyc.size();
    repeat (12) @(posedge clk);
    #1;
    chk("fr_nomore", pulse_cyc.size(), n);
    chk("fr_count", pulse_cyc.size() - base, 10);
    chk_period("fr_period", base, 5);
    wb_rd("fr_gen", 32'h014, 32'd10);

    // Burst of 5 with interrupt
    wb_wr("b_ctrl", 32'h000, 32'h8);
    wb_wr("b_div", 32'h00C, 32'h2);
    base = pulse_cyc.size();
    wb_wr("b_start", 32'h010, 32'h5);
    wb_rd("b_busy", 32'h018, 32'h1);
    repeat (25) @(posedge clk);
    #1;
    chk("b_count", pulse_cyc.size() - base, 5);
    chk_period("b_period", base, 3);
    wb_rd("b_stat", 32'h018, 32'h2);
    chk("b_irq", {31'h0, o_irq}, 32'h1);
    wb_rd("b_rem", 32'h010, 32'h0);
    wb_rd("b_gen", 32'h014, 32'd15);
    wb_wr("b_clr", 32'h018, 32'h2);
    chk("b_irq_clr", {31'h0, o_irq}, 32'h0);
    wb_rd("b_stat_clr", 32'h018, 32'h0);

    // Burst of 2 at TICK_DIV=0: back-to-back, no extra pulse
    wb_wr("b2_div", 32'h00C, 32'h0);
    base = pulse_cyc.size();
    wb_wr("b2_start", 32'h010, 32'h2);
    repeat (10) @(posedge clk);
    #1;
    chk("b2_count", pulse_cyc.size() - base, 2);
    chk_period("b2_period", base, 1);
    wb_rd("b2_stat", 32'h018, 32'h2);
    wb_wr("b2_clr", 32'h018, 32'h2);
    wb_rd("b2_gen", 32'h014, 32'd1);

    // Burst zero is ignored
    wb_wr("b0_start", 32'h010, 32'h0);
    wb_rd("b0_stat", 32'h018, 32'h0);

    // Abort burst after 3 pulses
    wb_wr("ab_div", 32'h00C, 32'h2);
    base = pulse_cyc.size();
    wb_wr("ab_start", 32'h010, 32'd100);
    n = 0;
    while (pulse_cyc.size() - base < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ab_wait", {31'h0, pulse_cyc.size() - base >= 3}, 32'h1);
    wb_wr("ab_stop", 32'h000, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("ab_count", pulse_cyc.size() - base, 3);
    wb_rd("ab_rem", 32'h010, 32'h0);
    wb_rd("ab_stat", 32'h018, 32'h0);
    wb_rd("ab_gen", 32'h014, 32'd4);

    // Generation counter wraps modulo 16
    wb_wr("w_clr", 32'h000, 32'h10);
    for (int i = 0; i < 15; i++)
      wb_wr("w_step", 32'h000, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    wb_rd("w_gen15", 32'h014, 32'd15);
    wb_wr("w_step16", 32'h000, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    wb_rd("w_gen0", 32'h014, 32'd0);
    wb_wr("w_step17", 32'h000, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    wb_rd("w_gen1", 32'h014, 32'd1);
    wb_wr("w_clr2", 32'h000, 32'h10);
    wb_rd("w_gen_c", 32'h014, 32'd0);

    // Direct register outputs
    wb_wr("o_wrap_wr", 32'h000, 32'h4);
    chk("o_wrap", {31'h0, o_wrap}, 32'h1);
    wb_rd("o_ctrl", 32'h000, 32'h4);
    wb_wr("o_max_wr", 32'h004, 32'h1);
    chk("o_en", {31'h0, o_max7219_enable}, 32'h1);
    chk("o_rev", {31'h0, o_max7219_reverse}, 32'h0);
    wb_wr("o_br_wr", 32'h008, 32'h35);
    chk("o_br", {28'h0, o_max7219_brightness}, 32'h5);
    wb_rd("o_br_rd", 32'h008, 32'h5);
    wb_wr("o_tick_wr", 32'h00C, 32'h12345678);
    wb_rd("o_tick_rd", 32'h00C, 32'h00345678);

    // Address decode
    xfer(1'b0, 32'h001000, 32'h0, r, g);
    chk("dec_rd_noack", {31'h0, g}, 32'h0);
    xfer(1'b1, 32'h001000, 32'h0, r, g);
    chk("dec_wr_noack", {31'h0, g}, 32'h0);
    chk("dec_wrap_kept", {31'h0, o_wrap}, 32'h1);
    wb_rd("dec_unmapped", 32'h000020, 32'h0);
    wb_wr("dec_unm_wr", 32'h000024, 32'hFFFFFFFF);
    wb_rd("dec_ctrl_kept", 32'h000, 32'h4);

    // Reset mid-burst abandons it
    wb_wr("r_div", 32'h00C, 32'h0);
    wb_wr("r_start", 32'h010, 32'd50);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n = pulse_cyc.size();
    repeat (8) @(posedge clk);
    #1;
    chk("r_nostep", pulse_cyc.size(), n);
    wb_rd("r_stat", 32'h018, 32'h0);
    wb_rd("r_gen", 32'h014, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/silife_ctrl.md
Name: silife_ctrl

Overview:
- Parametrised control/timing block for the SiLife cellular-automaton core.
- Replaces the fixed enable/clk_pulse control register with:
  - a programmable generation timer
  - burst stepping (run N generations, then stop)
  - a generation counter
  - a torus wrap-mode select
  - a completion interrupt
- Sits on the Wishbone bus beside the matrix Wishbone port. Drives the matrix step enable and the MAX7219 configuration outputs.

Parameters:
- WIDTH, 8, matrix columns; reported read-only in INFO.
- HEIGHT, 8, matrix rows; reported read-only in INFO.
- TIMER_BITS, 24, width of the tick divider and tick timer.
- GEN_BITS, 32, width of the generation counter (max 32).
- BURST_BITS, 16, width of the burst step counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  Wishbone write enable.
- i_wb_addr  in  32  Wishbone byte address; bits [23:0] decoded.
- i_wb_data  in  32  Wishbone write data.
- o_wb_ack  out  1  Wishbone acknowledge.
- o_wb_data  out  32  Wishbone read data.
- o_step  out  1  one-cycle pulse; matrix computes one generation.
- o_wrap  out  1  1 = torus edges (matrix edge inputs fed from the opposite edge).
- o_max7219_enable  out  1  display scan enable.
- o_max7219_reverse  out  1  reverse column order.
- o_max7219_brightness  out  4  display intensity.
- o_irq  out  1  level interrupt: done & irq_en.

Behaviour:
- Register map:
  - Selected only when i_wb_addr[23:12]==0. Other addresses get no ack and no state change.
  - 0x000 CTRL (RW):
    - bit0 run
    - bit1 step (write-1 pulse, reads 0)
    - bit2 wrap
    - bit3 irq_en
    - bit4 gen_clr (write-1 pulse, reads 0)
  - 0x004 MAX7219 (RW): bit0 enable, bit1 reverse.
  - 0x008 BRIGHTNESS (RW): [3:0].
  - 0x00C TICK_DIV (RW): [TIMER_BITS-1:0].
  - 0x010 BURST (RW): write N starts a burst; reads remaining count.
  - 0x014 GEN (RO).
  - 0x018 STATUS: bit0 busy (RO), bit1 done (write-1-to-clear).
  - 0x01C INFO (RO): {HEIGHT[15:0], WIDTH[15:0]}.
  - Unmapped in-window reads return 0 and still ack. Unmapped writes are acked and ignored.
- Wishbone handshake:
  - o_wb_ack <= stb & cyc & sel & !o_wb_ack, so it is high exactly one cycle after the request.
  - Read data is registered with the ack.
  - Unused register bits read 0.
- Reset values (reset_n low at a clk edge):
  - run=0, wrap=0, irq_en=0, done=0, GEN=0, BURST=0.
  - TICK_DIV=all ones.
  - max7219 enable=0, reverse=1, brightness=0xF.
  - o_step=0, o_wb_ack=0, o_wb_data=0, state=IDLE.
  - Reset mid-burst abandons the burst with no further o_step pulse.
- State machine:
  - IDLE:
    - CTRL write with step=1 gives o_step=1 in the cycle after the ack cycle.
    - CTRL run=1 goes to RUN.
    - BURST write N>0 goes to BURST. N=0 is ignored.
  - RUN: timer free-runs. CTRL run=0 returns to IDLE. BURST write N>0 goes to BURST.
  - BURST:
    - Each o_step decrements the remaining count.
    - The step that takes remaining to 0 sets done and goes to IDLE in the same edge.
    - CTRL run=0 aborts to IDLE, clears remaining, and does not set done.
    - A new BURST write restarts the count with the new N.
  - busy = (state != IDLE).
- Timer:
  - Cleared to 0 on entry to RUN or BURST.
  - Increments every cycle in RUN/BURST.
  - When timer==TICK_DIV: timer<=0 and o_step<=1 next cycle.
  - Step period is TICK_DIV+1 cycles; TICK_DIV=0 steps every cycle.
  - A TICK_DIV write while running takes effect immediately. If the new value is below the current timer, the timer runs on and wraps at 2^TIMER_BITS.
  - The step bit is ignored outside IDLE.
- GEN:
  - Increments on every o_step pulse and wraps modulo 2^GEN_BITS.
  - gen_clr forces 0 and wins over a simultaneous increment.
- STATUS done:
  - Set by burst completion, cleared by writing 1.
  - If set and clear happen in the same cycle, set wins.
- o_wrap and the MAX7219 outputs are direct register outputs.

Optional Feature:
- Macro: SILIFE_CTRL_STEP_GATE_EN.
- When defined:
  - Adds port i_step_gate (in, 1), e.g. MAX7219 frame-complete.
  - A timer expiry or manual step becomes pending. o_step fires in the cycle after the first cycle where pending & i_step_gate.
  - At most one pending step; further expiries while pending are dropped.
  - Leaving RUN/BURST by abort clears pending.
  - STATUS bit2 reads pending.
- When undefined: no port; o_step follows expiry directly as above; STATUS bit2 reads 0.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then read 0x008 -> 0x0000000F; read 0x00C -> 0x00FFFFFF (TIMER_BITS=24); read 0x01C -> 0x00080008; o_step stays 0.
- Manual step: write CTRL=0x2 three times -> exactly 3 o_step pulses, each one cycle after its ack; GEN reads 3.
- Free run: TICK_DIV=4, CTRL=0x1 for 50 cycles -> o_step period exactly 5 cycles; write CTRL=0 -> no further pulses; GEN equals the pulse count.
- Burst with interrupt: CTRL=0x8, TICK_DIV=2, BURST=5 -> exactly 5 pulses 3 cycles apart; STATUS reads 0x2 after the 5th pulse; o_irq=1; write STATUS=0x2 -> o_irq=0.
- Abort and wrap: BURST=100, write CTRL=0 after 3 pulses -> BURST reads 0, done=0; GEN preset via 0xFFFFFFFF steps (GEN_BITS=4: 15 steps) then 1 step -> GEN=0; CTRL=0x10 -> GEN=0.
- Address decode: read at 0x001000 -> no ack within 4 cycles; read at 0x000020 -> ack with data 0.
